// File: rtl/pipe_muldiv_unit_if.sv
// Issue/result bundle between ID/EXE hazard control and the iterative mul/div engine.
// master drives the operation request; slave is the engine.
interface pipe_muldiv_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start_i;
    logic [1:0]       op_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             cancel_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;
    logic             hi_wena_o;
    logic             lo_wena_o;

    modport master (
        output start_i, op_i, a_i, b_i, cancel_i,
        input  busy_o, done_o, hi_o, lo_o, hi_wena_o, lo_wena_o
    );

    modport slave (
        input  start_i, op_i, a_i, b_i, cancel_i,
        output busy_o, done_o, hi_o, lo_o, hi_wena_o, lo_wena_o
    );
endinterface

// File: rtl/pipe_muldiv_unit.sv
// Radix-2 iterative MULT/MULTU/DIV/DIVU engine: shift-add multiply, restoring divide,
// operating on magnitudes with a final sign-fix cycle.
module pipe_muldiv_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input logic               clk,
    input logic               rst,
    pipe_muldiv_unit_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_a_q, neg_a_d;
    logic               neg_b_q, neg_b_d;
    logic               b_zero_q, b_zero_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               a_sign, b_sign, div_ge;
    logic [WIDTH-1:0]   a_neg, b_neg, div_diff, quo_neg, rem_neg;
    logic [WIDTH:0]     mul_sum, div_shift;
    logic [2*WIDTH-1:0] prod, prod_neg;

    assign a_sign    = bus.op_i[0] & bus.a_i[WIDTH-1];
    assign b_sign    = bus.op_i[0] & bus.b_i[WIDTH-1];
    assign a_neg     = -bus.a_i;
    assign b_neg     = -bus.b_i;

    // acc_lo holds the multiplier (shifted out LSB first) or the dividend/quotient
    assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, opnd_q};
    assign div_diff  = div_shift[WIDTH-1:0] - opnd_q;
    assign prod      = {acc_hi_q, acc_lo_q};
    assign prod_neg  = -prod;
    assign quo_neg   = -acc_lo_q;
    assign rem_neg   = -acc_hi_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        b_zero_d = b_zero_q;
        opnd_d   = opnd_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (bus.start_i) begin
                    state_d  = StCalc;
                    cnt_d    = '0;
                    is_div_d = bus.op_i[1];
                    neg_a_d  = a_sign;
                    neg_b_d  = b_sign;
                    b_zero_d = (bus.b_i == '0);
                    opnd_d   = b_sign ? b_neg : bus.b_i;
                    acc_lo_d = a_sign ? a_neg : bus.a_i;
                    acc_hi_d = '0;
                end
            end
            StCalc: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (is_div_q) begin
                    acc_hi_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
                end else begin
                    {acc_hi_d, acc_lo_d} = {mul_sum, acc_lo_q[WIDTH-1:1]};
                end
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                state_d = StDone;
                if (is_div_q) begin
                    // Divide by zero: quotient stays all ones; remainder re-signs back to a
                    lo_d = ((neg_a_q ^ neg_b_q) && !b_zero_q) ? quo_neg : acc_lo_q;
                    hi_d = neg_a_q ? rem_neg : acc_hi_q;
                end else begin
                    {hi_d, lo_d} = (neg_a_q ^ neg_b_q) ? prod_neg : prod;
                end
            end
            default: state_d = StIdle;
        endcase

        if (bus.cancel_i) begin
            state_d = StIdle;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            b_zero_q <= 1'b0;
            opnd_q   <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            b_zero_q <= b_zero_d;
            opnd_q   <= opnd_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign bus.busy_o    = (state_q == StCalc) || (state_q == StFix);
    assign bus.done_o    = (state_q == StDone);
    assign bus.hi_wena_o = (state_q == StDone);
    assign bus.lo_wena_o = (state_q == StDone);
    assign bus.hi_o      = hi_q;
    assign bus.lo_o      = lo_q;

endmodule

// File: tb/tb_pipe_muldiv_unit.sv
// Bench for pipe_muldiv_unit: scoreboard of expected HI/LO pushed at issue, popped on done.
module tb_pipe_muldiv_unit;
    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_muldiv_unit_if #(.WIDTH(W)) bus ();

    pipe_muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    res_t sb[$];
    res_t last_exp;
    int   checks   = 0;
    int   failures = 0;

    function automatic res_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        res_t r;
        case (op)
            2'b00: begin p = {32'b0, a} * {32'b0, b}; r = res_t'(p); end
            2'b01: begin
                p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                r = res_t'(p);
            end
            2'b10: if (b == 0) r = {a, 32'hFFFF_FFFF}; else r = {a % b, a / b};
            default: begin
                if (b == 0) r = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
                else r = {$signed(a) % $signed(b), $signed(a) / $signed(b)};
            end
        endcase
        return r;
    endfunction

    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bus.start_i = 1'b1; bus.op_i = op; bus.a_i = a; bus.b_i = b;
        @(negedge clk);
        bus.start_i = 1'b0;
    endtask

    // Called at the negedge following the issuing edge; returns at the negedge with done_o high
    task automatic wait_done(output int cycles, output int busy_n, output bit to);
        cycles = 0;
        busy_n = (bus.busy_o === 1'b1) ? 1 : 0;
        to     = 1'b0;
        while (bus.done_o !== 1'b1) begin
            if (cycles >= 100) begin
                to = 1'b1;
                break;
            end
            @(negedge clk);
            cycles++;
            if (bus.busy_o === 1'b1) busy_n++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.start_i = 0; bus.cancel_i = 0; bus.op_i = 0; bus.a_i = 0; bus.b_i = 0;
        #12;
        checks++;
        if ({bus.busy_o, bus.done_o} !== 2'b00) begin
            failures++; $display("FAIL reset_busy_done got=%b exp=00", {bus.busy_o, bus.done_o});
        end
        checks++;
        if ({bus.hi_wena_o, bus.lo_wena_o} !== 2'b00) begin
            failures++; $display("FAIL reset_wena got=%b exp=00", {bus.hi_wena_o, bus.lo_wena_o});
        end
        checks++;
        if ({bus.hi_o, bus.lo_o} !== 64'h0) begin
            failures++; $display("FAIL reset_hilo got=%h_%h exp=0", bus.hi_o, bus.lo_o);
        end
        @(negedge clk);
        rst = 1'b0;
        last_exp = '0;
    endtask

    task automatic test_multu;
        int cyc, bsy; bit to; res_t exp;
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        sb.push_back({32'hFFFF_FFFE, 32'h0000_0001});
        wait_done(cyc, bsy, to);
        checks++;
        if (to) begin failures++; $display("FAIL multu_timeout got=none exp=done"); end
        checks++;
        if (cyc != 33) begin failures++; $display("FAIL multu_latency got=%0d exp=33", cyc); end
        checks++;
        if (bsy != 33) begin failures++; $display("FAIL multu_busy_cycles got=%0d exp=33", bsy); end
        exp = sb.pop_front();
        checks++;
        if ({bus.hi_o, bus.lo_o} !== exp) begin
            failures++; $display("FAIL multu_result got=%h_%h exp=%h_%h", bus.hi_o, bus.lo_o, exp.hi, exp.lo);
        end
        last_exp = exp;
        @(negedge clk);
        checks++;
        if (bus.done_o !== 1'b0) begin failures++; $display("FAIL multu_done_pulse got=1 exp=0"); end
        checks++;
        if ({bus.hi_o, bus.lo_o} !== last_exp) begin
            failures++; $display("FAIL multu_hold got=%h_%h exp=%h_%h", bus.hi_o, bus.lo_o, last_exp.hi, last_exp.lo);
        end
    endtask

    task automatic test_mult;
        int cyc, bsy; bit to; res_t exp;
        issue(2'b01, 32'hFFFF_FFFD, 32'd7);
        sb.push_back({32'hFFFF_FFFF, 32'hFFFF_FFEB});
        wait_done(cyc, bsy, to);
        checks++;
        if (to) begin failures++; $display("FAIL mult_timeout got=none exp=done"); end
        exp = sb.pop_front();
        checks++;
        if ({bus.hi_o, bus.lo_o} !== exp) begin
            failures++; $display("FAIL mult_result got=%h_%h exp=%h_%h", bus.hi_o, bus.lo_o, exp.hi, exp.lo);
        end
        checks++;
        if ({bus.hi_wena_o, bus.lo_wena_o} !== 2'b11) begin
            failures++; $display("FAIL mult_wena_high got=%b exp=11", {bus.hi_wena_o, bus.lo_wena_o});
        end
        last_exp = exp;
        @(negedge clk);
        checks++;
        if ({bus.hi_wena_o, bus.lo_wena_o} !== 2'b00) begin
            failures++; $display("FAIL mult_wena_pulse got=%b exp=00", {bus.hi_wena_o, bus.lo_wena_o});
        end
    endtask

    task automatic test_div;
        int cyc, bsy; bit to; res_t exp;
        logic [1:0]   ops [2] = '{2'b11, 2'b10};
        logic [W-1:0] as  [2] = '{32'hFFFF_FFF9, 32'd100};
        logic [W-1:0] bs  [2] = '{32'd2, 32'd7};
        res_t         xs  [2] = '{{32'hFFFF_FFFF, 32'hFFFF_FFFD}, {32'd2, 32'd14}};
        for (int i = 0; i < 2; i++) begin
            issue(ops[i], as[i], bs[i]);
            sb.push_back(xs[i]);
            wait_done(cyc, bsy, to);
            checks++;
            if (to) begin failures++; $display("FAIL div%0d_timeout got=none exp=done", i); sb.delete(); continue; end
            exp = sb.pop_front();
            checks++;
            if ({bus.hi_o, bus.lo_o} !== exp) begin
                failures++; $display("FAIL div%0d_result got=%h_%h exp=%h_%h", i, bus.hi_o, bus.lo_o, exp.hi, exp.lo);
            end
            last_exp = exp;
        end
    endtask

    task automatic test_div_edge;
        int cyc, bsy; bit to; res_t exp;
        logic [1:0]   ops [3] = '{2'b10, 2'b11, 2'b11};
        logic [W-1:0] as  [3] = '{32'd5, 32'hFFFF_FFF7, 32'h8000_0000};
        logic [W-1:0] bs  [3] = '{32'd0, 32'd0, 32'hFFFF_FFFF};
        res_t         xs  [3] = '{{32'd5, 32'hFFFF_FFFF}, {32'hFFFF_FFF7, 32'hFFFF_FFFF},
                                  {32'h0, 32'h8000_0000}};
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], as[i], bs[i]);
            sb.push_back(xs[i]);
            wait_done(cyc, bsy, to);
            checks++;
            if (to || cyc != 33) begin
                failures++; $display("FAIL edge%0d_latency got=%0d exp=33", i, cyc);
                if (to) begin sb.delete(); continue; end
            end
            exp = sb.pop_front();
            checks++;
            if ({bus.hi_o, bus.lo_o} !== exp) begin
                failures++; $display("FAIL edge%0d_result got=%h_%h exp=%h_%h", i, bus.hi_o, bus.lo_o, exp.hi, exp.lo);
            end
            last_exp = exp;
        end
    endtask

    task automatic test_cancel;
        int done_seen = 0;
        issue(2'b10, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        // cancel wins over a simultaneous start
        bus.cancel_i = 1'b1; bus.start_i = 1'b1; bus.op_i = 2'b00; bus.a_i = 32'd3; bus.b_i = 32'd3;
        @(negedge clk);
        bus.cancel_i = 1'b0; bus.start_i = 1'b0;
        checks++;
        if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL cancel_busy got=%b exp=0", bus.busy_o); end
        checks++;
        if ({bus.hi_o, bus.lo_o} !== last_exp) begin
            failures++; $display("FAIL cancel_hilo got=%h_%h exp=%h_%h", bus.hi_o, bus.lo_o, last_exp.hi, last_exp.lo);
        end
        repeat (40) begin
            @(negedge clk);
            if (bus.done_o === 1'b1 || bus.hi_wena_o === 1'b1) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin failures++; $display("FAIL cancel_no_done got=%0d exp=0", done_seen); end
        checks++;
        if ({bus.hi_o, bus.lo_o} !== last_exp) begin
            failures++; $display("FAIL cancel_hold got=%h_%h exp=%h_%h", bus.hi_o, bus.lo_o, last_exp.hi, last_exp.lo);
        end
    endtask

    task automatic test_ignore_start;
        int cyc, bsy, extra = 0; bit to; res_t exp;
        issue(2'b00, 32'd6, 32'd7);
        sb.push_back({32'd0, 32'd42});
        repeat (5) @(negedge clk);
        bus.start_i = 1'b1; bus.op_i = 2'b10; bus.a_i = 32'd9; bus.b_i = 32'd3;
        @(negedge clk);
        bus.start_i = 1'b0;
        wait_done(cyc, bsy, to);
        checks++;
        if (to) begin failures++; $display("FAIL ignore_timeout got=none exp=done"); sb.delete(); return; end
        exp = sb.pop_front();
        checks++;
        if ({bus.hi_o, bus.lo_o} !== exp) begin
            failures++; $display("FAIL ignore_result got=%h_%h exp=%h_%h", bus.hi_o, bus.lo_o, exp.hi, exp.lo);
        end
        last_exp = exp;
        repeat (40) begin
            @(negedge clk);
            if (bus.done_o === 1'b1) extra++;
        end
        checks++;
        if (extra != 0) begin failures++; $display("FAIL ignore_no_queue got=%0d exp=0", extra); end
    endtask

    task automatic test_async_reset;
        int cyc, bsy; bit to; res_t exp;
        issue(2'b01, 32'd12345, 32'hFFFF_FFFE);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.busy_o, bus.done_o, bus.hi_wena_o, bus.lo_wena_o} !== 4'b0000) begin
            failures++; $display("FAIL arst_ctrl got=%b exp=0000",
                                 {bus.busy_o, bus.done_o, bus.hi_wena_o, bus.lo_wena_o});
        end
        checks++;
        if ({bus.hi_o, bus.lo_o} !== 64'h0) begin
            failures++; $display("FAIL arst_hilo got=%h_%h exp=0", bus.hi_o, bus.lo_o);
        end
        @(negedge clk);
        rst = 1'b0;
        last_exp = '0;
        issue(2'b00, 32'h0001_0000, 32'h0001_0000);
        sb.push_back({32'd1, 32'd0});
        wait_done(cyc, bsy, to);
        checks++;
        if (to) begin failures++; $display("FAIL arst_timeout got=none exp=done"); sb.delete(); return; end
        exp = sb.pop_front();
        checks++;
        if ({bus.hi_o, bus.lo_o} !== exp) begin
            failures++; $display("FAIL arst_result got=%h_%h exp=%h_%h", bus.hi_o, bus.lo_o, exp.hi, exp.lo);
        end
        last_exp = exp;
    endtask

    task automatic test_back_to_back;
        int cyc, bsy; bit to; res_t exp;
        issue(2'b10, 32'hFFFF_FFFF, 32'h10);
        sb.push_back({32'hF, 32'h0FFF_FFFF});
        wait_done(cyc, bsy, to);
        checks++;
        if (to) begin failures++; $display("FAIL b2b_first_timeout got=none exp=done"); sb.delete(); return; end
        exp = sb.pop_front();
        checks++;
        if ({bus.hi_o, bus.lo_o} !== exp) begin
            failures++; $display("FAIL b2b_first got=%h_%h exp=%h_%h", bus.hi_o, bus.lo_o, exp.hi, exp.lo);
        end
        // Issue during the DONE cycle
        bus.start_i = 1'b1; bus.op_i = 2'b11; bus.a_i = 32'h7FFF_FFFF; bus.b_i = 32'hFFFF_0000;
        sb.push_back({32'h0000_FFFF, 32'hFFFF_8001});
        @(negedge clk);
        bus.start_i = 1'b0;
        wait_done(cyc, bsy, to);
        checks++;
        if (to || cyc + 1 != 34) begin failures++; $display("FAIL b2b_gap got=%0d exp=34", cyc + 1); end
        if (to) begin sb.delete(); return; end
        exp = sb.pop_front();
        checks++;
        if ({bus.hi_o, bus.lo_o} !== exp) begin
            failures++; $display("FAIL b2b_second got=%h_%h exp=%h_%h", bus.hi_o, bus.lo_o, exp.hi, exp.lo);
        end
        last_exp = exp;
    endtask

    task automatic test_random;
        int cyc, bsy; bit to; res_t exp;
        logic [1:0] op; logic [W-1:0] a, b;
        for (int i = 0; i < 12; i++) begin
            op = 2'(i % 4);
            a  = $urandom;
            b  = (i == 6) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
            if (i % 5 == 1) a = -a;
            issue(op, a, b);
            sb.push_back(model(op, a, b));
            wait_done(cyc, bsy, to);
            checks++;
            if (to) begin failures++; $display("FAIL rand%0d_timeout got=none exp=done", i); sb.delete(); continue; end
            exp = sb.pop_front();
            checks++;
            if ({bus.hi_o, bus.lo_o} !== exp) begin
                failures++;
                $display("FAIL rand%0d op=%b a=%h b=%h got=%h_%h exp=%h_%h",
                         i, op, a, b, bus.hi_o, bus.lo_o, exp.hi, exp.lo);
            end
            last_exp = exp;
        end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_div_edge();
        test_cancel();
        test_ignore_start();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
